mini_alu_param: RTL
===================

MINI_ALU_PARAM -- requirements
Module: mini_alu_param

Interface
REQ-001 Parameter DATA_WIDTH, default 16; width of data registers and ALU datapath.
REQ-002 Parameter ADDR_WIDTH, default 8; width of each operand/destination field in the instruction.
REQ-003 Parameter REG_DEPTH, default 16; number of internal data registers (REG_DEPTH <= 2**ADDR_WIDTH).
REQ-004 Parameter LED_WIDTH, default 8; width of oLed.
REQ-005 Clock  input  1  single system clock; all state updates on its rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 oIP  output  ADDR_WIDTH  instruction address presented to an external combinational ROM.
REQ-008 iInstruction  input  4+3*ADDR_WIDTH  instruction read from ROM at oIP, fields {op[3:0], dst, src1, src0}.
REQ-009 oLed  output  LED_WIDTH  registered LED value.
REQ-010 oBusy  output  1  high while a multi-cycle operation stalls the pipeline.

Function
REQ-011 The block SHALL be a two-stage pipeline: fetch (IP register, instruction register IR) and execute (decode of IR, register-file read, ALU, write-back).
REQ-012 Opcodes SHALL be: 0 NOP, 1 ADD, 2 STO, 3 BLE, 4 JMP, 5 LED, 6 SUB, 7 AND, 8 OR, 9 BEQ, 10 MUL; 11-15 SHALL execute as NOP.
REQ-013 Register reads SHALL be combinational from IR src0/src1; register-file indices SHALL use the low clog2(REG_DEPTH) bits of each field.
REQ-014 ADD: R[dst]=R[src1]+R[src0]; SUB: R[dst]=R[src0]-R[src1]; AND/OR bitwise; all results truncated modulo 2**DATA_WIDTH, no carry/flags.
REQ-015 STO: R[dst]={src1,src0} zero-extended or truncated to DATA_WIDTH.
REQ-016 Write-back SHALL occur on the rising edge ending the execute cycle; the next executed instruction SHALL see the new value (no hazard, no forwarding needed).
REQ-017 BLE taken iff R[src1] <= R[src0] (unsigned); BEQ taken iff R[src1] == R[src0]; JMP always taken; target = dst field.
REQ-018 On a taken branch, IP SHALL load target and IR SHALL load NOP (one bubble cycle); not-taken branches cost no extra cycle.
REQ-019 Without a taken branch or stall, IP SHALL increment by 1 each cycle, wrapping from 2**ADDR_WIDTH-1 to 0.
REQ-020 LED: oLed SHALL load R[src1][LED_WIDTH-1:0] (zero-extended if LED_WIDTH > DATA_WIDTH) at the end of the execute cycle; oLed SHALL hold otherwise.
REQ-021 MUL (when compiled in) SHALL use a state machine IDLE -> MUL -> IDLE performing shift-add over DATA_WIDTH cycles.
REQ-022 On entering MUL, oBusy SHALL be 1 from the next cycle until the final iteration cycle inclusive; IP and IR SHALL hold throughout.
REQ-023 MUL SHALL write the low DATA_WIDTH bits of R[src1]*R[src0] to R[dst] at the end of the final iteration; total execute occupancy DATA_WIDTH+1 cycles.
REQ-024 MUL operands SHALL be latched on entry; dst==src is legal and yields the product of the original values.

Reset
REQ-025 Reset SHALL set IP=0, IR=NOP, all registers=0, oLed=0, oBusy=0, state=IDLE.
REQ-026 Reset asserted during MUL SHALL abort it with no register write; Reset SHALL take priority over branch, stall and write-back in the same cycle.
REQ-027 oIP SHALL be 0 in the first cycle after Reset deasserts; the instruction at address 0 executes in the following cycle.

Configuration
REQ-028 Macro MINI_ALU_MUL_EN: defined -> MUL per REQ-021..024; undefined -> opcode 10 executes as NOP in one cycle, oBusy tied 0, no multiplier state built.

Verification
REQ-029 STO R1=5; STO R2=3; ADD R3=R2+R1; LED R3 -> oLed=8 four cycles after the STO R1 cycle.
REQ-030 STO R1=0xFFFF; STO R2=1; ADD R3 -> R3=0x0000 (wrap); SUB R4=R2-R1 -> R4=0x0002.
REQ-031 R1=2, R2=2; BLE dst=0x10 at IP 5 -> oIP=0x10 next cycle, instruction fetched at IP 6 is NOP'd; R2=3 -> not taken, no bubble.
REQ-032 MUL_EN defined, R1=7, R2=6, MUL R3 -> oBusy high 16 cycles, IP frozen, R3=42 afterwards; undefined -> R3 unchanged, oBusy 0.
REQ-033 Reset asserted at MUL iteration 8 -> R3 unchanged-from-reset (0), oBusy=0, oIP=0 next cycle.
REQ-034 JMP to 0xFF repeated with IP reaching 0xFF and no branch -> oIP wraps to 0x00.

Source files
------------

// File: rtl/mini_alu_param_if.sv
// mini_alu_param_if
//   Bus between the mini ALU core and its environment (instruction ROM and
//   LED / status observers).
//   Signals:
//     oIP          : instruction address from the core to a combinational ROM
//     iInstruction : instruction word read from the ROM at oIP,
//                    fields {op[3:0], dst, src1, src0}
//     oLed         : registered LED value
//     oBusy        : high while a multi-cycle multiply stalls the pipeline
//   Modports:
//     master : core side (drives oIP, oLed, oBusy; receives iInstruction)
//     slave  : environment side (drives iInstruction; observes the rest)
interface mini_alu_param_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int LED_WIDTH  = 8
);
  logic [ADDR_WIDTH-1:0]     oIP;
  logic [4+3*ADDR_WIDTH-1:0] iInstruction;
  logic [LED_WIDTH-1:0]      oLed;
  logic                      oBusy;

  modport master (output oIP, input iInstruction, output oLed, output oBusy);
  modport slave  (input oIP, output iInstruction, input oLed, input oBusy);
endinterface

// File: rtl/mini_alu_param.sv
// mini_alu_param
//   Two-stage (fetch / execute) parameterised mini processor with a small
//   register file, branch unit, LED output register and an optional
//   shift-add multiplier.
//   Ports:
//     Clock : system clock, all state changes on its rising edge
//     Reset : synchronous, active-high reset
//     bus   : mini_alu_param_if.master (oIP, iInstruction, oLed, oBusy)
//   Build option:
//     MINI_ALU_MUL_EN : when defined, opcode 10 (MUL) runs a DATA_WIDTH-cycle
//                       shift-add multiply and stalls fetch meanwhile; when
//                       undefined, opcode 10 is a plain NOP and oBusy is 0.
module mini_alu_param #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int REG_DEPTH  = 16,
  parameter int LED_WIDTH  = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  mini_alu_param_if.master bus
);

  localparam int INSTR_WIDTH = 4 + 3*ADDR_WIDTH;
  localparam int IDX_WIDTH   = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_STO = 4'd2;
  localparam logic [3:0] OP_BLE = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_LED = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_AND = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_BEQ = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = {INSTR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0]  IP_STEP   = ADDR_WIDTH'(1'b1);

  // Fetch stage state
  logic [ADDR_WIDTH-1:0]  ip;
  logic [INSTR_WIDTH-1:0] ir;

  // Architectural state
  logic [DATA_WIDTH-1:0] rf [REG_DEPTH];
  logic [LED_WIDTH-1:0]  led;
  logic                  busy;

  // Decoded instruction fields
  logic [3:0]            op;
  logic [ADDR_WIDTH-1:0] dst;
  logic [ADDR_WIDTH-1:0] src1;
  logic [ADDR_WIDTH-1:0] src0;
  logic [IDX_WIDTH-1:0]  dst_idx;
  logic [IDX_WIDTH-1:0]  src1_idx;
  logic [IDX_WIDTH-1:0]  src0_idx;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd0;

  // Execute results
  logic                  alu_we;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  taken;
  logic                  led_we;
  logic                  stall;
  logic                  mul_we;
  logic [IDX_WIDTH-1:0]  mul_dst;
  logic [DATA_WIDTH-1:0] mul_result;

  assign {op, dst, src1, src0} = ir;

  // Only the low index bits address the register file; the full fields are
  // still meaningful as branch target and STO immediate.
  assign dst_idx  = dst[IDX_WIDTH-1:0];
  assign src1_idx = src1[IDX_WIDTH-1:0];
  assign src0_idx = src0[IDX_WIDTH-1:0];

  assign rd1 = rf[src1_idx];
  assign rd0 = rf[src0_idx];

  assign bus.oIP   = ip;
  assign bus.oLed  = led;
  assign bus.oBusy = busy;

`ifdef MINI_ALU_MUL_EN
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_STEP = CNT_WIDTH'(1'b1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  mul_start;
  logic                  mul_last;
  logic [DATA_WIDTH-1:0] mul_a;
  logic [DATA_WIDTH-1:0] mul_b;
  logic [DATA_WIDTH-1:0] mul_acc;
  logic [CNT_WIDTH-1:0]  mul_cnt;
`endif

  // Execute-stage decode: ALU result, branch decision and LED load.
  always_comb begin
    alu_we   = 1'b0;
    alu_data = {DATA_WIDTH{1'b0}};
    taken    = 1'b0;
    led_we   = 1'b0;
`ifdef MINI_ALU_MUL_EN
    mul_start = 1'b0;
`endif
    case (op)
      OP_NOP: begin
      end
      OP_ADD: begin
        alu_we   = 1'b1;
        alu_data = rd1 + rd0;
      end
      OP_STO: begin
        // {src1, src0} immediate, zero-extended or truncated by the cast
        alu_we   = 1'b1;
        alu_data = DATA_WIDTH'({src1, src0});
      end
      OP_BLE: begin
        taken = (rd1 <= rd0);
      end
      OP_JMP: begin
        taken = 1'b1;
      end
      OP_LED: begin
        led_we = 1'b1;
      end
      OP_SUB: begin
        alu_we   = 1'b1;
        alu_data = rd0 - rd1;
      end
      OP_AND: begin
        alu_we   = 1'b1;
        alu_data = rd1 & rd0;
      end
      OP_OR: begin
        alu_we   = 1'b1;
        alu_data = rd1 | rd0;
      end
      OP_BEQ: begin
        taken = (rd1 == rd0);
      end
`ifdef MINI_ALU_MUL_EN
      OP_MUL: begin
        // Only acted on in IDLE; while iterating IR still holds the MUL.
        mul_start = 1'b1;
      end
`else
      OP_MUL: begin
      end
`endif
      default: begin
      end
    endcase
  end

`ifdef MINI_ALU_MUL_EN
  // Multiplier FSM state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Multiplier FSM next state; fetch is held from entry until the last
  // iteration, on which the product is written and fetch resumes.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    mul_we     = 1'b0;
    case (state)
      S_IDLE: begin
        if (mul_start) begin
          state_next = S_MUL;
          stall      = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_MUL: begin
        if (mul_last) begin
          state_next = S_IDLE;
          mul_we     = 1'b1;
        end else begin
          state_next = S_MUL;
          stall      = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign mul_last   = (mul_cnt == CNT_LAST);
  assign mul_result = mul_acc + (mul_b[0] ? mul_a : {DATA_WIDTH{1'b0}});

  // Shift-add datapath: operands are captured on entry so dst may alias a
  // source without disturbing the product.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mul_a   <= {DATA_WIDTH{1'b0}};
      mul_b   <= {DATA_WIDTH{1'b0}};
      mul_acc <= {DATA_WIDTH{1'b0}};
      mul_cnt <= {CNT_WIDTH{1'b0}};
      mul_dst <= {IDX_WIDTH{1'b0}};
    end else if ((state == S_IDLE) && mul_start) begin
      mul_a   <= rd1;
      mul_b   <= rd0;
      mul_acc <= {DATA_WIDTH{1'b0}};
      mul_cnt <= {CNT_WIDTH{1'b0}};
      mul_dst <= dst_idx;
    end else if (state == S_MUL) begin
      mul_acc <= mul_result;
      mul_a   <= mul_a << 1'b1;
      mul_b   <= mul_b >> 1'b1;
      mul_cnt <= mul_cnt + CNT_STEP;
    end else begin
      mul_a   <= mul_a;
      mul_b   <= mul_b;
      mul_acc <= mul_acc;
      mul_cnt <= mul_cnt;
      mul_dst <= mul_dst;
    end
  end

  // Busy flag: high from the cycle after entry through the last iteration.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_next == S_MUL);
    end
  end
`else
  assign stall      = 1'b0;
  assign mul_we     = 1'b0;
  assign mul_dst    = {IDX_WIDTH{1'b0}};
  assign mul_result = {DATA_WIDTH{1'b0}};
  assign busy       = 1'b0;
`endif

  // Fetch stage: IP/IR advance, hold on stall, or redirect with a bubble.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ip <= {ADDR_WIDTH{1'b0}};
      ir <= INSTR_NOP;
    end else if (stall) begin
      ip <= ip;
      ir <= ir;
    end else if (taken) begin
      ip <= dst;
      ir <= INSTR_NOP;
    end else begin
      ip <= ip + IP_STEP;
      ir <= bus.iInstruction;
    end
  end

  // Register file write-back at the end of the execute cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        rf[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (mul_we) begin
      rf[mul_dst] <= mul_result;
    end else if (alu_we) begin
      rf[dst_idx] <= alu_data;
    end
  end

  // LED register: loads the low bits of R[src1] on an LED instruction.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      led <= {LED_WIDTH{1'b0}};
    end else if (led_we) begin
      led <= LED_WIDTH'(rd1);
    end else begin
      led <= led;
    end
  end

endmodule
